prbs16_check: RTL and testbench

- Serial receive-side checker for the team's PRBS16 pattern (feedback = b15^b12^b11^b10, shift toward MSB, feedback enters b0).
- Self-synchronises a local LFSR from the incoming bit stream, confirms lock, then counts bit errors.
- Declares loss of lock when the error density gets too high.
- Sits at the far end of a link or loopback path driven by the PRBS16 generator. The transmitted serial bit is the new b0 produced on each generator shift.

---
 rtl/prbs16_check.sv | 151 +++++++++++++++
 tb/tb_prbs16_check.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs16_check.sv
// PRBS16 receive checker: self-synchronises a local b15^b12^b11^b10 LFSR to the
// incoming serial stream, confirms lock, then counts bit errors and error density.
module prbs16_check #(
    parameter int unsigned LOCK_CNT    = 32,
    parameter int unsigned WIN_LEN     = 128,
    parameter int unsigned LOSS_THRESH = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bitEn,
    input  logic             inBit,
    input  logic             clrCnt,
    output logic             locked,
    output logic             errFlag,
    output logic [CNT_W-1:0] errCnt,
    output logic [CNT_W-1:0] bitCnt
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W   = $clog2(WIN_LEN + 1);
    localparam int WERR_W  = $clog2(LOSS_THRESH + 1);

    typedef enum logic [1:0] {
        SEED,
        VERIFY,
        LOCKED
    } state_t;

    state_t             state;
    logic [15:0]        chk_reg;
    logic [3:0]         seed_cnt;
    logic [MATCH_W-1:0] match_cnt;
    logic [WIN_W-1:0]   win_cnt;
    logic [WERR_W-1:0]  win_err;

    logic               pred;
    logic               mismatch;
    logic [15:0]        seed_shift;
    logic [15:0]        pred_shift;
    logic [MATCH_W-1:0] match_nxt;
    logic               lock_done;
    logic [WIN_W-1:0]   win_nxt;
    logic               win_wrap;
    logic [WERR_W-1:0]  win_err_nxt;
    logic               loss;
    logic               bit_evt;
    logic               err_evt;

    assign pred       = chk_reg[15] ^ chk_reg[12] ^ chk_reg[11] ^ chk_reg[10];
    assign mismatch   = inBit ^ pred;
    assign seed_shift = {chk_reg[14:0], inBit};
    assign pred_shift = {chk_reg[14:0], pred};

    assign match_nxt  = match_cnt + MATCH_W'(1);
    assign lock_done  = (match_nxt == MATCH_W'(LOCK_CNT));

    // An error on the wrapping bit is the first error of the new window.
    assign win_nxt     = win_cnt + WIN_W'(1);
    assign win_wrap    = (win_nxt == WIN_W'(WIN_LEN));
    assign win_err_nxt = (win_wrap ? '0 : win_err) + WERR_W'(mismatch);
    assign loss        = (win_err_nxt == WERR_W'(LOSS_THRESH));

    assign bit_evt = bitEn && (state == LOCKED);
    assign err_evt = bit_evt && mismatch;

    // Clear first, then count, then saturate at all-ones.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                   input logic             clr,
                                                   input logic             evt);
        logic [CNT_W-1:0] base;
        base = clr ? '0 : cur;
        if (evt && (base != '1))
            return base + CNT_W'(1);
        return base;
    endfunction

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SEED;
            chk_reg   <= '0;
            seed_cnt  <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            locked    <= 1'b0;
            errFlag   <= 1'b0;
        end else begin
            errFlag <= 1'b0;
            if (bitEn) begin
                case (state)
                    SEED: begin
                        chk_reg <= seed_shift;
                        if (seed_cnt == 4'd15) begin
                            seed_cnt <= '0;
                            if (seed_shift != 16'h0000)
                                state <= VERIFY;
                        end else begin
                            seed_cnt <= seed_cnt + 4'd1;
                        end
                    end
                    VERIFY: begin
                        chk_reg <= seed_shift;
                        if (mismatch) begin
                            state     <= SEED;
                            seed_cnt  <= 4'd1;
                            match_cnt <= '0;
                        end else if (lock_done) begin
                            state     <= LOCKED;
                            locked    <= 1'b1;
                            match_cnt <= '0;
                            win_cnt   <= '0;
                            win_err   <= '0;
                        end else begin
                            match_cnt <= match_nxt;
                        end
                    end
                    LOCKED: begin
                        // Feed back the prediction so a line error cannot poison later bits.
                        chk_reg <= pred_shift;
                        errFlag <= mismatch;
                        if (loss) begin
                            state     <= SEED;
                            locked    <= 1'b0;
                            seed_cnt  <= '0;
                            match_cnt <= '0;
                            win_cnt   <= '0;
                            win_err   <= '0;
                        end else begin
                            win_cnt <= win_wrap ? '0 : win_nxt;
                            win_err <= win_err_nxt;
                        end
                    end
                    default: state <= SEED;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            errCnt <= '0;
            bitCnt <= '0;
        end else begin
            errCnt <= cnt_next(errCnt, clrCnt, err_evt);
            bitCnt <= cnt_next(bitCnt, clrCnt, bit_evt);
        end
    end

endmodule

// File: tb/tb_prbs16_check.sv
// Scoreboard bench for prbs16_check: a sequence-level reference model predicts
// every cycle's outputs; a monitor pops and compares one cycle after each edge.
module tb_prbs16_check;

    localparam int LOCK_CNT    = 32;
    localparam int WIN_LEN     = 128;
    localparam int LOSS_THRESH = 8;
    localparam int CNT_W       = 16;
    localparam int NW_W        = 4;
    localparam int MAX_W       = (1 << CNT_W) - 1;
    localparam int MAX_NW      = (1 << NW_W) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            bitEn;
    logic            inBit;
    logic            clrCnt;
    logic            locked;
    logic            errFlag;
    logic [CNT_W-1:0] errCnt;
    logic [CNT_W-1:0] bitCnt;
    logic            nw_locked;
    logic            nw_errFlag;
    logic [NW_W-1:0] nw_errCnt;
    logic [NW_W-1:0] nw_bitCnt;

    always #5 clk = ~clk;

    prbs16_check dut (
        .clk(clk), .rst(rst), .bitEn(bitEn), .inBit(inBit), .clrCnt(clrCnt),
        .locked(locked), .errFlag(errFlag), .errCnt(errCnt), .bitCnt(bitCnt)
    );

    // Narrow-counter copy on the same stream so saturation is reachable quickly.
    prbs16_check #(.CNT_W(NW_W)) dut_nw (
        .clk(clk), .rst(rst), .bitEn(bitEn), .inBit(inBit), .clrCnt(clrCnt),
        .locked(nw_locked), .errFlag(nw_errFlag), .errCnt(nw_errCnt), .bitCnt(nw_bitCnt)
    );

    typedef struct {
        bit lk;
        bit fl;
        int ec;
        int bc;
        int ecn;
        int bcn;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    typedef enum {PH_SEED, PH_VERIFY, PH_LOCKED} phase_t;

    phase_t      m_phase;
    bit          m_hist[$];
    int          m_seed_n, m_streak, m_idx, m_win, m_win_err;
    bit          m_locked, m_flag;
    int          m_ec, m_bc, m_ecn, m_bcn;
    logic [15:0] gen = 16'hFFFF;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int bump(input int cur, input bit clr, input bit evt, input int max);
        int v;
        v = clr ? 0 : cur;
        if (evt && v < max) v++;
        return v;
    endfunction

    task automatic model_reset();
        m_phase = PH_SEED;
        m_hist.delete();
        repeat (16) m_hist.push_back(1'b0);
        m_seed_n = 0; m_streak = 0; m_idx = 0; m_win = 0; m_win_err = 0;
        m_locked = 0; m_flag = 0;
        m_ec = 0; m_bc = 0; m_ecn = 0; m_bcn = 0;
    endtask

    task automatic push_hist(input bit v);
        m_hist.push_back(v);
        void'(m_hist.pop_front());
    endtask

    // m_hist holds the local sequence, oldest first; the PRBS rule predicts
    // x[n] = x[n-16] ^ x[n-13] ^ x[n-12] ^ x[n-11].
    task automatic model_step(input bit en, input bit b, input bit clr);
        bit p, e_evt, b_evt, nz;
        int w;
        e_evt = 0; b_evt = 0; m_flag = 0;
        if (en) begin
            p = m_hist[$-15] ^ m_hist[$-12] ^ m_hist[$-11] ^ m_hist[$-10];
            case (m_phase)
                PH_SEED: begin
                    push_hist(b);
                    m_seed_n++;
                    if (m_seed_n == 16) begin
                        m_seed_n = 0;
                        nz = 0;
                        for (int i = 0; i < 16; i++) if (m_hist[i]) nz = 1;
                        if (nz) begin m_phase = PH_VERIFY; m_streak = 0; end
                    end
                end
                PH_VERIFY: begin
                    push_hist(b);
                    if (b == p) begin
                        m_streak++;
                        if (m_streak == LOCK_CNT) begin
                            m_phase = PH_LOCKED; m_locked = 1;
                            m_idx = 0; m_win = 0; m_win_err = 0;
                        end
                    end else begin
                        m_phase = PH_SEED; m_seed_n = 1; m_streak = 0;
                    end
                end
                default: begin
                    push_hist(p);
                    b_evt = 1;
                    w = (m_idx + 1) / WIN_LEN;
                    if (w != m_win) begin m_win = w; m_win_err = 0; end
                    if (b != p) begin e_evt = 1; m_flag = 1; m_win_err++; end
                    m_idx++;
                    if (m_win_err == LOSS_THRESH) begin
                        m_phase = PH_SEED; m_locked = 0; m_seed_n = 0; m_streak = 0;
                    end
                end
            endcase
        end
        m_ec  = bump(m_ec,  clr, e_evt, MAX_W);
        m_bc  = bump(m_bc,  clr, b_evt, MAX_W);
        m_ecn = bump(m_ecn, clr, e_evt, MAX_NW);
        m_bcn = bump(m_bcn, clr, b_evt, MAX_NW);
    endtask

    task automatic push_exp();
        exp_t e;
        e.lk = m_locked; e.fl = m_flag;
        e.ec = m_ec; e.bc = m_bc; e.ecn = m_ecn; e.bcn = m_bcn;
        sb_q.push_back(e);
    endtask

    task automatic step(input bit en, input bit b, input bit clr);
        @(negedge clk);
        bitEn = en; inBit = b; clrCnt = clr;
        model_step(en, b, clr);
        push_exp();
    endtask

    task automatic send(input bit en, input bit flip, input bit clr);
        bit b;
        b = 0;
        if (en) begin
            b = gen[15] ^ gen[12] ^ gen[11] ^ gen[10];
            gen = {gen[14:0], b};
            b = b ^ flip;
        end
        step(en, b, clr);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int n);
        repeat (n) begin
            @(negedge clk);
            rst = 0; bitEn = 0; inBit = 0; clrCnt = 0;
            model_reset();
            push_exp();
        end
        @(negedge clk);
        rst = 1;
        model_step(0, 0, 0);
        push_exp();
    endtask

    task automatic align_window();
        int guard;
        guard = 0;
        while (m_phase == PH_LOCKED && ((m_idx + 1) % WIN_LEN) != 0 && guard < WIN_LEN) begin
            send(1, 0, 0);
            guard++;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("sb_locked",     locked,     e.lk);
                check("sb_errFlag",    errFlag,    e.fl);
                check("sb_errCnt",     errCnt,     e.ec);
                check("sb_bitCnt",     bitCnt,     e.bc);
                check("sb_nw_locked",  nw_locked,  e.lk);
                check("sb_nw_errCnt",  nw_errCnt,  e.ecn);
                check("sb_nw_bitCnt",  nw_bitCnt,  e.bcn);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        bit en;
        int n_en, iter, gap;
        rst = 1; bitEn = 0; inBit = 0; clrCnt = 0;
        model_reset();
        #2 rst = 0;
        #1;
        check("rst_locked",  locked,  0);
        check("rst_errFlag", errFlag, 0);
        check("rst_errCnt",  errCnt,  0);
        check("rst_bitCnt",  bitCnt,  0);
        do_reset(3);

        // Clean stream from a generator seeded 16'hFFFF: lock on sample 48.
        repeat (47) send(1, 0, 0);
        settle();
        check("lock_after_47", locked, 0);
        send(1, 0, 0);
        settle();
        check("lock_after_48", locked, 1);
        check("lock_errCnt",   errCnt, 0);
        check("lock_bitCnt",   bitCnt, 0);

        // Single flipped bit (the 1000th) while locked.
        repeat (951) send(1, 0, 0);
        send(1, 1, 0);
        settle();
        check("single_errFlag", errFlag, 1);
        check("single_errCnt",  errCnt,  1);
        check("single_locked",  locked,  1);
        send(1, 0, 0);
        settle();
        check("single_flag_end", errFlag, 0);
        repeat (198) send(1, 0, 0);
        settle();
        check("single_no_more_err", errCnt, 1);
        check("single_bitCnt",      bitCnt, 1151);

        // Eight errors inside one window force resynchronisation.
        send(1, 0, 1);
        align_window();
        for (int k = 0; k < 8; k++) begin
            send(1, 1, 0);
            if (k < 7) begin
                gap = $urandom_range(0, 10);
                repeat (gap) send(1, 0, 0);
            end
        end
        settle();
        check("loss_locked", locked, 0);
        check("loss_errCnt", errCnt, 8);
        repeat (47) send(1, 0, 0);
        settle();
        check("relock_after_47", locked, 0);
        send(1, 0, 0);
        settle();
        check("relock_after_48", locked, 1);
        check("relock_errCnt",   errCnt, 8);

        // Saturation on the narrow instance, then clear-and-count.
        for (int k = 0; k < 20; k++) begin
            send(1, 1, 0);
            repeat (19) send(1, 0, 0);
        end
        settle();
        check("sat_nw_errCnt", nw_errCnt, MAX_NW);
        check("sat_errCnt",    errCnt,    28);
        check("sat_locked",    locked,    1);
        align_window();
        send(1, 1, 0);
        settle();
        check("sat_nw_hold", nw_errCnt, MAX_NW);
        check("sat_errCnt2", errCnt,    29);
        send(1, 1, 1);
        settle();
        check("clr_err_errCnt",    errCnt,    1);
        check("clr_err_nw_errCnt", nw_errCnt, 1);
        check("clr_err_errFlag",   errFlag,   1);

        // All-zero input never leaves SEED.
        do_reset(2);
        repeat (500) step(1, 0, 0);
        settle();
        check("zeros_locked", locked, 0);
        check("zeros_errCnt", errCnt, 0);

        // Random bitEn gaps: lock after 48 enabled samples.
        do_reset(2);
        gen = 16'hFFFF;
        n_en = 0; iter = 0;
        while (n_en < 48 && iter < 1000) begin
            en = 1'($urandom_range(0, 1));
            send(en, 0, 0);
            iter++;
            if (en) begin
                n_en++;
                if (n_en == 47) begin
                    settle();
                    check("gap_lock_after_47", locked, 0);
                end else if (n_en == 48) begin
                    settle();
                    check("gap_lock_after_48", locked, 1);
                end
            end
        end
        check("gap_enabled_samples", n_en, 48);
        check("gap_errCnt", errCnt, 0);

        // Randomised traffic: gaps, sparse errors, occasional clears.
        repeat (300) send(1'($urandom_range(0, 1)), ($urandom_range(0, 199) == 0),
                          ($urandom_range(0, 29) == 0));

        // Asynchronous reset mid-stream clears outputs immediately.
        @(posedge clk);
        #3 rst = 0;
        #1;
        check("async_locked",  locked,     0);
        check("async_errFlag", errFlag,    0);
        check("async_errCnt",  errCnt,     0);
        check("async_bitCnt",  bitCnt,     0);
        check("async_nw_cnt",  nw_bitCnt,  0);
        do_reset(2);
        repeat (47) send(1, 0, 0);
        settle();
        check("reset_relock_47", locked, 0);
        send(1, 0, 0);
        settle();
        check("reset_relock_48", locked, 1);

        repeat (3) send(0, 0, 0);
        settle();
        settle();
        check("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
